// File: rtl/inc_counter.sv
// Loadable up-counter whose next count comes from a parallel-prefix incrementer.
// The prefix-AND structure (serial, Brent-Kung or Sklansky) is chosen by the speed parameter.
module inc_counter #(
  parameter int width    = 8,
  parameter int speed    = 0,
  parameter bit saturate = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             load_i,
  input  logic [width-1:0] load_val_i,
  input  logic             en_i,
  output logic [width-1:0] cnt_o,
  output logic             tc_o,
  output logic             wrap_o,
  output logic             ovf_o
);

  localparam int levels = (width > 1) ? $clog2(width) : 1;

  // po[i] = &a[i:0]. Each network updates in place; within one level a node is
  // never both written and read as the lower operand, so the order of i is free.
  function automatic logic [width-1:0] prefix_and(input logic [width-1:0] a);
    logic [width-1:0] g;
    g = a;
    if (speed == 0) begin
      for (int i = 1; i < width; i++) g[i] = g[i-1] & a[i];
    end else if (speed == 1) begin
      for (int l = 0; l < levels; l++)
        for (int i = 0; i < width; i++)
          if (((i + 1) % (1 << (l + 1))) == 0) g[i] = g[i] & g[i - (1 << l)];
      for (int l = levels - 2; l >= 0; l--)
        for (int i = 0; i < width; i++)
          if ((((i + 1) % (1 << (l + 1))) == (1 << l)) && ((i + 1) > (1 << (l + 1))))
            g[i] = g[i] & g[i - (1 << l)];
    end else begin
      // Sklansky: the upper half of each 2^(l+1) block takes the lower half's top node.
      for (int l = 0; l < levels; l++)
        for (int i = 0; i < width; i++)
          if (((i >> l) & 1) == 1) g[i] = g[i] & g[((i >> l) << l) - 1];
    end
    return g;
  endfunction

  logic [width-1:0] po;
  logic [width-1:0] inc;

  assign po   = prefix_and(cnt_o);
  assign inc  = cnt_o ^ {po[width-2:0], 1'b1};
  assign tc_o = po[width-1];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_o  <= '0;
      wrap_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else if (clr_i) begin
      cnt_o  <= '0;
      wrap_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else if (load_i) begin
      cnt_o  <= load_val_i;
      wrap_o <= 1'b0;
      ovf_o  <= 1'b0;
    end else if (en_i) begin
      if (tc_o) begin
        ovf_o <= 1'b1;
        if (saturate) begin
          wrap_o <= 1'b0;
        end else begin
          cnt_o  <= '0;
          wrap_o <= 1'b1;
        end
      end else begin
        cnt_o  <= inc;
        wrap_o <= 1'b0;
      end
    end else begin
      wrap_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_inc_counter.sv
// Five counters (8-bit wrap/saturate, 13-bit at each speed) share one stimulus stream
// and are compared every cycle against an arithmetic reference model.
module tb_inc_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, clr, load, en;
  logic [12:0] lv;
  logic [7:0]  cnt_a, cnt_b;
  logic [12:0] cnt_c [3];
  logic [4:0]  tc, wrap, ovf;
  logic [12:0] obs [5];

  inc_counter #(.width(8), .speed(2), .saturate(1'b0)) u_w8_wrap (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(lv[7:0]),
    .en_i(en), .cnt_o(cnt_a), .tc_o(tc[0]), .wrap_o(wrap[0]), .ovf_o(ovf[0]));

  inc_counter #(.width(8), .speed(1), .saturate(1'b1)) u_w8_sat (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(lv[7:0]),
    .en_i(en), .cnt_o(cnt_b), .tc_o(tc[1]), .wrap_o(wrap[1]), .ovf_o(ovf[1]));

  for (genvar g = 0; g < 3; g++) begin : g_w13
    inc_counter #(.width(13), .speed(g), .saturate(1'b0)) u_w13 (
      .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .load_i(load), .load_val_i(lv),
      .en_i(en), .cnt_o(cnt_c[g]), .tc_o(tc[2+g]), .wrap_o(wrap[2+g]), .ovf_o(ovf[2+g]));
  end

  assign obs[0] = {5'b0, cnt_a};
  assign obs[1] = {5'b0, cnt_b};
  assign obs[2] = cnt_c[0];
  assign obs[3] = cnt_c[1];
  assign obs[4] = cnt_c[2];

  // reference model
  int     widths [5] = '{8, 8, 13, 13, 13};
  bit     sat_m  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
  longint m_cnt  [5];
  bit     m_wrap [5];
  bit     m_ovf  [5];

  int checks = 0;
  int errors = 0;
  logic [12:0] exp_q [$];

  function automatic longint mask(int i);
    return (longint'(1) << widths[i]) - 1;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) begin
      m_cnt[i] = 0; m_wrap[i] = 1'b0; m_ovf[i] = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 5; i++) begin
      m_wrap[i] = 1'b0;
      if (clr) begin
        m_cnt[i] = 0; m_ovf[i] = 1'b0;
      end else if (load) begin
        m_cnt[i] = longint'(lv) & mask(i); m_ovf[i] = 1'b0;
      end else if (en) begin
        if (m_cnt[i] == mask(i)) begin
          m_ovf[i] = 1'b1;
          if (!sat_m[i]) begin
            m_cnt[i] = 0; m_wrap[i] = 1'b1;
          end
        end else begin
          m_cnt[i] = (m_cnt[i] + 1) % (mask(i) + 1);
        end
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("cnt[%0d]", i), 64'(obs[i]), 64'(m_cnt[i]));
      chk($sformatf("tc[%0d]", i), 64'(tc[i]), 64'(m_cnt[i] == mask(i)));
      chk($sformatf("wrap[%0d]", i), 64'(wrap[i]), 64'(m_wrap[i]));
      chk($sformatf("ovf[%0d]", i), 64'(ovf[i]), 64'(m_ovf[i]));
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic drive(input logic c, input logic l, input logic e, input logic [12:0] v);
    clr = c; load = l; en = e; lv = v;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 13'h0);
    model_reset();
    #2;
    check_all();
    step();
    step();
    rst_n = 1'b1;

    // count up from reset
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    for (int k = 1; k <= 5; k++) exp_q.push_back(13'(k));
    repeat (5) begin
      step();
      chk("seq_cnt", 64'(cnt_a), 64'(exp_q.pop_front()));
    end

    // wrap at width 8
    drive(1'b0, 1'b1, 1'b0, 13'h0FE);
    step();
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    step();
    chk("wrap_ff", 64'(cnt_a), 64'h0FF);
    chk("wrap_tc", 64'(tc[0]), 64'h1);
    step();
    chk("wrap_zero", 64'(cnt_a), 64'h0);
    chk("wrap_pulse", 64'(wrap[0]), 64'h1);
    chk("wrap_ovf", 64'(ovf[0]), 64'h1);
    step();
    chk("wrap_pulse_end", 64'(wrap[0]), 64'h0);
    chk("wrap_ovf_sticky", 64'(ovf[0]), 64'h1);

    // saturate at width 8
    drive(1'b0, 1'b1, 1'b0, 13'h0FF);
    step();
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    repeat (3) begin
      step();
      chk("sat_hold", 64'(cnt_b), 64'h0FF);
      chk("sat_nowrap", 64'(wrap[1]), 64'h0);
      chk("sat_ovf", 64'(ovf[1]), 64'h1);
    end

    // priority clr > load > en
    drive(1'b0, 1'b1, 1'b0, 13'h040);
    step();
    drive(1'b1, 1'b1, 1'b1, 13'h055);
    step();
    chk("prio_clr", 64'(cnt_a), 64'h0);
    drive(1'b0, 1'b1, 1'b0, 13'h0FF);
    step();
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    step();
    chk("prio_ovf_set", 64'(ovf[0]), 64'h1);
    drive(1'b0, 1'b1, 1'b1, 13'h03C);
    step();
    chk("prio_load", 64'(cnt_a), 64'h03C);
    chk("prio_ovf_clr", 64'(ovf[0]), 64'h0);

    // carry through partial groups at width 13
    drive(1'b0, 1'b1, 1'b0, 13'h0FFF);
    step();
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    step();
    for (int g = 0; g < 3; g++) chk($sformatf("carry13_s%0d", g), 64'(cnt_c[g]), 64'h1000);
    drive(1'b0, 1'b1, 1'b0, 13'h1FFF);
    step();
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    step();
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("wrap13_s%0d", g), 64'(cnt_c[g]), 64'h0);
      chk($sformatf("wrap13_pulse_s%0d", g), 64'(wrap[2+g]), 64'h1);
    end
    drive(1'b0, 1'b0, 1'b0, 13'h0);
    step();

    // random traffic, loads biased toward all-ones
    for (int n = 0; n < 1000; n++) begin
      logic [12:0] v;
      int pick;
      pick = $urandom_range(0, 3);
      if (pick == 0)      v = 13'h1FFF - 13'($urandom_range(0, 3));
      else if (pick == 1) v = 13'h00FF - 13'($urandom_range(0, 3));
      else                v = 13'($urandom_range(0, 8191));
      drive(1'($urandom_range(0, 99) < 3), 1'($urandom_range(0, 99) < 12),
            1'($urandom_range(0, 9) < 8), v);
      step();
    end

    // asynchronous reset between edges
    drive(1'b0, 1'b1, 1'b0, 13'h07A);
    step();
    drive(1'b0, 1'b0, 1'b1, 13'h0);
    chk("areset_pre", 64'(cnt_a), 64'h07A);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("areset_cnt", 64'(cnt_a), 64'h0);
    chk("areset_ovf", 64'(ovf[0]), 64'h0);
    check_all();
    step();
    rst_n = 1'b1;
    step();
    chk("areset_resume", 64'(cnt_a), 64'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
